// File: rtl/serial_alu_pkg.sv
// Shared definitions for the bit-serial ALU sequencer: op codes, FSM states
// and small op-classification helpers.
package serial_alu_pkg;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_XOR = 3'b010;
    localparam logic [2:0] OP_ADD = 3'b011;
    localparam logic [2:0] OP_SUB = 3'b100;
    localparam logic [2:0] OP_SLT = 3'b101;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FINISH = 2'd2,
        DONE   = 2'd3
    } state_t;

    // Codes 110 and 111 are unassigned.
    function automatic logic is_legal_op(input logic [2:0] op);
        return (op <= OP_SLT);
    endfunction

    // Ops that run the full adder and produce carry/overflow.
    function automatic logic is_arith_op(input logic [2:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_SLT);
    endfunction

    // Ops computed as a + ~b + 1.
    function automatic logic is_sub_op(input logic [2:0] op);
        return (op == OP_SUB) || (op == OP_SLT);
    endfunction

endpackage

// File: rtl/serial_bit_slice.sv
// One-bit ALU slice: AND/OR/XOR or full add, with optional inversion of b.
module serial_bit_slice
    import serial_alu_pkg::*;
(
    input  logic [2:0] op,
    input  logic       a_bit,
    input  logic       b_bit,
    input  logic       cin,
    input  logic       b_inv,
    output logic       r,
    output logic       cout
);

    logic bx;
    assign bx = b_bit ^ b_inv;

    // Select the bit function; carry-out is only meaningful for arithmetic.
    always_comb begin
        r    = 1'b0;
        cout = 1'b0;
        case (op)
            OP_AND: r = a_bit & bx;
            OP_OR:  r = a_bit | bx;
            OP_XOR: r = a_bit ^ bx;
            OP_ADD, OP_SUB, OP_SLT: begin
                r    = a_bit ^ bx ^ cin;
                cout = (a_bit & bx) | (a_bit & cin) | (bx & cin);
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/serial_alu_sequencer.sv
// Bit-serial ALU controller: shifts operands LSB first through one bit slice,
// carries between cycles, assembles the result and raises status flags.
module serial_alu_sequencer
    import serial_alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             result_valid,
    input  logic             result_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow,
    output logic             zero,
    output logic             err,
    output logic             busy
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_t            state_reg, state_next;
    logic [WIDTH-1:0]  a_sh_reg, b_sh_reg, res_sh_reg;
    logic [2:0]        op_reg;
    logic              carry_reg;
    logic [CNT_W-1:0]  cnt_reg;
    logic              cin_msb_reg, cout_msb_reg;
    logic [WIDTH-1:0]  result_reg;
    logic              carry_out_reg, overflow_reg, zero_reg, err_reg;
    logic              result_valid_reg;

    logic              accept, last_bit;
    logic              slice_r, slice_cout;
    logic              ovf_fin, carry_fin;
    logic [WIDTH-1:0]  result_fin;

    assign start_ready  = (state_reg == IDLE);
    assign busy         = (state_reg == RUN) || (state_reg == FINISH);
    assign accept       = start_valid && start_ready;
    assign last_bit     = (cnt_reg == CNT_W'(WIDTH - 1));

    assign result       = result_reg;
    assign carry_out    = carry_out_reg;
    assign overflow     = overflow_reg;
    assign zero         = zero_reg;
    assign err          = err_reg;
    assign result_valid = result_valid_reg;

    serial_bit_slice u_slice (
        .op    (op_reg),
        .a_bit (a_sh_reg[0]),
        .b_bit (b_sh_reg[0]),
        .cin   (carry_reg),
        .b_inv (is_sub_op(op_reg)),
        .r     (slice_r),
        .cout  (slice_cout)
    );

    // Final flags and result word, from the MSB carries captured during RUN.
    always_comb begin
        carry_fin  = is_arith_op(op_reg) & cout_msb_reg;
        ovf_fin    = is_arith_op(op_reg) & (cin_msb_reg ^ cout_msb_reg);
        result_fin = res_sh_reg;
        if (op_reg == OP_SLT) begin
            result_fin = {{(WIDTH-1){1'b0}}, res_sh_reg[WIDTH-1] ^ ovf_fin};
        end
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_reg <= IDLE;
        else       state_reg <= state_next;
    end

    // Next-state logic; DONE waits for the valid flag to be up before a take.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (accept) state_next = is_legal_op(op) ? RUN : DONE;
            RUN:     if (last_bit) state_next = FINISH;
            FINISH:  state_next = DONE;
            DONE:    if (result_valid_reg && result_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath: operand capture, serial shifting, output registers and the
    // valid flag, which rises one edge after the word lands in DONE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_sh_reg         <= '0;
            b_sh_reg         <= '0;
            res_sh_reg       <= '0;
            op_reg           <= OP_AND;
            carry_reg        <= 1'b0;
            cnt_reg          <= '0;
            cin_msb_reg      <= 1'b0;
            cout_msb_reg     <= 1'b0;
            result_reg       <= '0;
            carry_out_reg    <= 1'b0;
            overflow_reg     <= 1'b0;
            zero_reg         <= 1'b0;
            err_reg          <= 1'b0;
            result_valid_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        a_sh_reg     <= a;
                        b_sh_reg     <= b;
                        op_reg       <= op;
                        carry_reg    <= is_sub_op(op);
                        cnt_reg      <= '0;
                        res_sh_reg   <= '0;
                        cin_msb_reg  <= 1'b0;
                        cout_msb_reg <= 1'b0;
                        if (!is_legal_op(op)) begin
                            result_reg    <= '0;
                            carry_out_reg <= 1'b0;
                            overflow_reg  <= 1'b0;
                            zero_reg      <= 1'b0;
                            err_reg       <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    res_sh_reg <= {slice_r, res_sh_reg[WIDTH-1:1]};
                    a_sh_reg   <= {1'b0, a_sh_reg[WIDTH-1:1]};
                    b_sh_reg   <= {1'b0, b_sh_reg[WIDTH-1:1]};
                    carry_reg  <= slice_cout;
                    cnt_reg    <= cnt_reg + CNT_W'(1);
                    if (last_bit) begin
                        cin_msb_reg  <= carry_reg;
                        cout_msb_reg <= slice_cout;
                    end
                end
                FINISH: begin
                    result_reg    <= result_fin;
                    carry_out_reg <= carry_fin;
                    overflow_reg  <= ovf_fin;
                    zero_reg      <= (result_fin == '0);
                    err_reg       <= 1'b0;
                end
                DONE: begin
                    if (!result_valid_reg)  result_valid_reg <= 1'b1;
                    else if (result_ready)  result_valid_reg <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_alu_sequencer.sv
// Directed bench for serial_alu_sequencer (WIDTH=8).
module tb_serial_alu_sequencer;

    logic       clk;
    logic       reset;
    logic       start_valid;
    logic       start_ready;
    logic [2:0] op;
    logic [7:0] a, b;
    logic       result_valid;
    logic       result_ready;
    logic [7:0] result;
    logic       carry_out, overflow, zero, err, busy;

    int tests = 0;
    int fails = 0;

    serial_alu_sequencer #(.WIDTH(8)) dut (
        .clk          (clk),
        .reset        (reset),
        .start_valid  (start_valid),
        .start_ready  (start_ready),
        .op           (op),
        .a            (a),
        .b            (b),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .result       (result),
        .carry_out    (carry_out),
        .overflow     (overflow),
        .zero         (zero),
        .err          (err),
        .busy         (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Present one request, then wait (bounded) for result_valid at a negedge.
    // lat counts edges after the accepting edge; bc counts busy cycles.
    task automatic launch(input logic [2:0] o, input logic [7:0] ai, input logic [7:0] bi,
                          output int lat, output int bc);
        @(negedge clk);
        op = o; a = ai; b = bi; start_valid = 1'b1;
        check("accept_ready", start_ready, 1);
        @(posedge clk);
        #1;
        start_valid = 1'b0;
        op = 3'b110; a = 8'hA5; b = 8'h5A;
        lat = 0;
        bc  = 0;
        while (lat < 40) begin
            @(negedge clk);
            if (result_valid) break;
            if (busy) bc++;
            @(posedge clk);
            lat++;
        end
    endtask

    task automatic take_result(input string tag);
        @(negedge clk);
        result_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        result_ready = 1'b0;
        check({tag, "_valid_cleared"}, result_valid, 0);
        check({tag, "_ready_again"}, start_ready, 1);
    endtask

    task automatic run_op(input string tag, input logic [2:0] o, input logic [7:0] ai,
                          input logic [7:0] bi, input logic [7:0] er, input logic ec,
                          input logic ev, input logic ez, input logic ee);
        int lat, bc;
        launch(o, ai, bi, lat, bc);
        $display("[TB] %s op=%0d a=0x%02h b=0x%02h -> result=0x%02h c=%0b v=%0b z=%0b err=%0b lat=%0d",
                 tag, o, ai, bi, result, carry_out, overflow, zero, err, lat);
        check({tag, "_result"}, result, er);
        check({tag, "_carry"}, carry_out, ec);
        check({tag, "_ovf"}, overflow, ev);
        check({tag, "_zero"}, zero, ez);
        check({tag, "_err"}, err, ee);
        check({tag, "_latency"}, lat, ee ? 1 : 10);
        check({tag, "_busy_cycles"}, bc, ee ? 0 : 9);
        take_result(tag);
    endtask

    initial begin
        int lat, bc;
        reset = 1'b1; start_valid = 1'b0; op = 3'b000; a = '0; b = '0; result_ready = 1'b0;

        repeat (2) @(negedge clk);
        check("rst_ready", start_ready, 1);
        check("rst_valid", result_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_result", result, 0);
        check("rst_flags", {carry_out, overflow, zero, err}, 0);
        reset = 1'b0;

        // Logic ops
        run_op("and", 3'b000, 8'hCA, 8'h0F, 8'h0A, 0, 0, 0, 0);
        run_op("or",  3'b001, 8'hCA, 8'h0F, 8'hCF, 0, 0, 0, 0);
        run_op("xor", 3'b010, 8'hCA, 8'h0F, 8'hC5, 0, 0, 0, 0);
        // Arithmetic
        run_op("add_ovf",  3'b011, 8'h7F, 8'h01, 8'h80, 0, 1, 0, 0);
        run_op("sub_zero", 3'b100, 8'h05, 8'h05, 8'h00, 1, 0, 1, 0);
        run_op("add_wrap", 3'b011, 8'hFF, 8'h01, 8'h00, 1, 0, 1, 0);
        // Signed less-than
        run_op("slt_80_01", 3'b101, 8'h80, 8'h01, 8'h01, 1, 1, 0, 0);
        run_op("slt_01_80", 3'b101, 8'h01, 8'h80, 8'h00, 0, 1, 1, 0);
        run_op("slt_fe_ff", 3'b101, 8'hFE, 8'hFF, 8'h01, 0, 0, 0, 0);
        // Illegal op
        run_op("illegal", 3'b111, 8'h12, 8'h34, 8'h00, 0, 0, 0, 1);

        // Backpressure: hold result while a new request is presented
        launch(3'b010, 8'hCA, 8'h0F, lat, bc);
        check("bp_latency", lat, 10);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            start_valid = 1'b1; op = 3'b011; a = 8'h01; b = 8'h01;
            $display("[TB] backpressure cycle %0d result=0x%02h valid=%0b start_ready=%0b",
                     i, result, result_valid, start_ready);
            check("bp_result", result, 8'hC5);
            check("bp_valid", result_valid, 1);
            check("bp_start_ready", start_ready, 0);
            check("bp_busy", busy, 0);
        end
        @(negedge clk);
        start_valid = 1'b0;
        check("bp_result_end", result, 8'hC5);
        take_result("bp");
        @(negedge clk);
        check("bp_not_accepted", busy, 0);

        // Reset during RUN
        @(negedge clk);
        op = 3'b011; a = 8'h12; b = 8'h34; start_valid = 1'b1;
        @(posedge clk);
        #1 start_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        $display("[TB] reset mid-run result=0x%02h valid=%0b busy=%0b start_ready=%0b",
                 result, result_valid, busy, start_ready);
        check("mid_rst_result", result, 0);
        check("mid_rst_valid", result_valid, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_ready", start_ready, 1);
        check("mid_rst_flags", {carry_out, overflow, zero, err}, 0);
        // A request presented while reset is high is ignored
        @(negedge clk);
        start_valid = 1'b1; op = 3'b011; a = 8'h01; b = 8'h02;
        @(posedge clk);
        @(negedge clk);
        check("rst_ignore_busy", busy, 0);
        check("rst_ignore_ready", start_ready, 1);
        start_valid = 1'b0;
        reset = 1'b0;
        run_op("add_after_rst", 3'b011, 8'h12, 8'h34, 8'h46, 0, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
